// File: rtl/intersection_pkg.sv
// rtl/intersection_pkg.sv - phase encodings, default tick counts and lamp helper for intersection_controller
package intersection_pkg;

  typedef enum logic [2:0] {
    RST_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_NS2EW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    RED_EW2NS = 3'd6,
    PED_WALK  = 3'd7
  } phase_e;

  localparam int DEF_GREEN_TICKS  = 8;
  localparam int DEF_YELLOW_TICKS = 3;
  localparam int DEF_ALLRED_TICKS = 2;
  localparam int DEF_WALK_TICKS   = 6;
  localparam int DEF_TW           = 8;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  // One direction's lamps: green/yellow only in its own phases, red everywhere else.
  function automatic lamp_t lamp_for(phase_e p, phase_e green_ph, phase_e yellow_ph);
    lamp_t l;
    l.green  = (p == green_ph);
    l.yellow = (p == yellow_ph);
    l.red    = !((p == green_ph) || (p == yellow_ph));
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that expires on a strobe while at zero
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          i_clk,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_tick_en,
  output logic          o_expire
);

  logic [TW-1:0] r_count;

  // Holding at zero lets a resting phase re-check its exit condition on every strobe.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick_en && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_expire = (r_count == '0) && i_tick_en;

endmodule

// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - two-way intersection phase sequencer; PED_REQ_EN adds pedestrian walk
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int WALK_TICKS   = DEF_WALK_TICKS,
  parameter int TW           = DEF_TW
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick_en,
  input  logic       i_ns_car,
  input  logic       i_ew_car,
`ifdef PED_REQ_EN
  input  logic       i_ped_req,
  output logic       o_ped_ack,
  output logic       o_walk,
`endif
  output logic       o_ns_red,
  output logic       o_ns_yellow,
  output logic       o_ns_green,
  output logic       o_ew_red,
  output logic       o_ew_yellow,
  output logic       o_ew_green,
  output logic [2:0] o_phase
);

  phase_e        r_phase;
  phase_e        w_next;
  logic          w_expire;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_ped_pending;
  logic          w_unused_ns_car;

  assign w_unused_ns_car = i_ns_car;

`ifdef PED_REQ_EN
  logic r_ped_pending;

  // A request arriving on the walk-entry cycle stays pending for the next round.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ped_pending <= 1'b0;
      o_ped_ack     <= 1'b0;
    end else begin
      o_ped_ack <= i_ped_req && !r_ped_pending;
      if (i_ped_req) begin
        r_ped_pending <= 1'b1;
      end else if ((w_next == PED_WALK) && (r_phase != PED_WALK)) begin
        r_ped_pending <= 1'b0;
      end
    end
  end

  assign w_ped_pending = r_ped_pending;
`else
  assign w_ped_pending = 1'b0;
`endif

  always_comb begin
    w_next = r_phase;
    case (r_phase)
      RST_RED:   if (w_expire) w_next = NS_GREEN;
      NS_GREEN:  if (w_expire && (i_ew_car || w_ped_pending)) w_next = NS_YELLOW;
      NS_YELLOW: if (w_expire) w_next = RED_NS2EW;
      RED_NS2EW: if (w_expire) w_next = EW_GREEN;
      EW_GREEN:  if (w_expire) w_next = EW_YELLOW;
      EW_YELLOW: if (w_expire) w_next = RED_EW2NS;
      RED_EW2NS: if (w_expire) w_next = w_ped_pending ? PED_WALK : NS_GREEN;
`ifdef PED_REQ_EN
      PED_WALK:  if (w_expire) w_next = NS_GREEN;
`else
      PED_WALK:  w_next = RST_RED;
`endif
      default:   w_next = RST_RED;
    endcase
  end

  always_comb begin
    w_load = i_reset || (w_next != r_phase);
    case (i_reset ? RST_RED : w_next)
      NS_GREEN, EW_GREEN:   w_load_val = TW'(GREEN_TICKS - 1);
      NS_YELLOW, EW_YELLOW: w_load_val = TW'(YELLOW_TICKS - 1);
      PED_WALK:             w_load_val = TW'(WALK_TICKS - 1);
      default:              w_load_val = TW'(ALLRED_TICKS - 1);
    endcase
  end

  phase_timer #(.TW(TW)) u_timer (
    .i_clk      (i_clk),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick_en  (i_tick_en),
    .o_expire   (w_expire)
  );

  // Lamps are decoded from the next phase so they switch on the same edge as the phase register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= RST_RED;
      {o_ns_red, o_ns_yellow, o_ns_green} <= 3'b100;
      {o_ew_red, o_ew_yellow, o_ew_green} <= 3'b100;
`ifdef PED_REQ_EN
      o_walk <= 1'b0;
`endif
    end else begin
      r_phase <= w_next;
      {o_ns_red, o_ns_yellow, o_ns_green} <= lamp_for(w_next, NS_GREEN, NS_YELLOW);
      {o_ew_red, o_ew_yellow, o_ew_green} <= lamp_for(w_next, EW_GREEN, EW_YELLOW);
`ifdef PED_REQ_EN
      o_walk <= (w_next == PED_WALK);
`endif
    end
  end

  assign o_phase = r_phase;

endmodule

// File: tb/tb_intersection_controller.sv
// tb/tb_intersection_controller.sv - directed table-driven bench for intersection_controller (PED_REQ_EN aware)
module tb_intersection_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic       ns_car;
  logic       ew_car;
`ifdef PED_REQ_EN
  logic       ped_req;
  logic       ped_ack;
  logic       walk;
`endif
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic [2:0] phase;

  always #5 clk = ~clk;

  intersection_controller dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_tick_en   (tick_en),
    .i_ns_car    (ns_car),
    .i_ew_car    (ew_car),
`ifdef PED_REQ_EN
    .i_ped_req   (ped_req),
    .o_ped_ack   (ped_ack),
    .o_walk      (walk),
`endif
    .o_ns_red    (ns_red),
    .o_ns_yellow (ns_yellow),
    .o_ns_green  (ns_green),
    .o_ew_red    (ew_red),
    .o_ew_yellow (ew_yellow),
    .o_ew_green  (ew_green),
    .o_phase     (phase)
  );

  // Lamp vectors {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  localparam logic [5:0] L_RR = 6'b100_100;
  localparam logic [5:0] L_GR = 6'b001_100;
  localparam logic [5:0] L_YR = 6'b010_100;
  localparam logic [5:0] L_RG = 6'b100_001;
  localparam logic [5:0] L_RY = 6'b100_010;

  typedef struct packed {
    logic       rst;
    logic       tick;
    logic       ew;
    logic       ped;
    logic [7:0] cnt;
    logic [2:0] ph;
    logic [5:0] lamps;
    logic       walk;
    logic       ack;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic t, input logic e, input logic p, input int c,
                     input logic [2:0] ph, input logic [5:0] l, input logic w, input logic a);
    vec_t v;
    v.rst = r; v.tick = t; v.ew = e; v.ped = p; v.cnt = 8'(c);
    v.ph = ph; v.lamps = l; v.walk = w; v.ack = a;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] eph, input logic [5:0] el,
                       input logic ew_exp, input logic ea_exp);
    logic [5:0] lamps;
    logic       aw, aa, ok;
    lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
`ifdef PED_REQ_EN
    aw = walk;
    aa = ped_ack;
    ok = (phase === eph) && (lamps === el) && (aw === ew_exp) && (aa === ea_exp);
`else
    aw = 1'b0;
    aa = 1'b0;
    ok = (phase === eph) && (lamps === el);
`endif
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d lamps=%b walk=%b ack=%b, want phase=%0d lamps=%b walk=%b ack=%b",
               name, phase, lamps, aw, aa, eph, el, ew_exp, ea_exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_en = 1'b1; ew_car = 1'b0; ns_car = 1'b0;
`ifdef PED_REQ_EN
    ped_req = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len[8];
    int base[7];
    int run, started;
    logic [2:0] prev, cur;

    // Reset, resting NS green, one full EW round, reset mid-EW_YELLOW
    add(1,1,0,0, 3, 0, L_RR, 0,0);
    add(0,1,0,0, 1, 0, L_RR, 0,0);
    add(0,1,0,0, 1, 1, L_GR, 0,0);
    add(0,1,0,0,50, 1, L_GR, 0,0);
    add(0,1,1,0, 3, 2, L_YR, 0,0);
    add(0,1,1,0, 2, 3, L_RR, 0,0);
    add(0,1,1,0, 8, 4, L_RG, 0,0);
    add(0,1,1,0, 3, 5, L_RY, 0,0);
    add(0,1,1,0, 2, 6, L_RR, 0,0);
    add(0,1,1,0, 8, 1, L_GR, 0,0);
    add(0,1,1,0, 1, 2, L_YR, 0,0);
    add(0,1,0,0, 2, 2, L_YR, 0,0);
    add(0,1,0,0, 2, 3, L_RR, 0,0);
    add(0,1,0,0, 8, 4, L_RG, 0,0);
    add(0,1,0,0, 3, 5, L_RY, 0,0);
    add(0,1,0,0, 2, 6, L_RR, 0,0);
    add(0,1,0,0,10, 1, L_GR, 0,0);
    add(0,1,1,0, 3, 2, L_YR, 0,0);
    add(0,1,1,0, 2, 3, L_RR, 0,0);
    add(0,1,1,0, 8, 4, L_RG, 0,0);
    add(0,1,1,0, 1, 5, L_RY, 0,0);
    add(1,1,0,0, 1, 0, L_RR, 0,0);
    add(0,1,0,0, 1, 0, L_RR, 0,0);
    add(0,1,0,0, 1, 1, L_GR, 0,0);
    add(0,1,0,0, 5, 1, L_GR, 0,0);
`ifdef PED_REQ_EN
    // Pedestrian-only round with a second request inside the walk
    add(0,1,0,1, 1, 1, L_GR, 0,1);
    add(0,1,0,0, 3, 2, L_YR, 0,0);
    add(0,1,0,0, 2, 3, L_RR, 0,0);
    add(0,1,0,0, 8, 4, L_RG, 0,0);
    add(0,1,0,0, 3, 5, L_RY, 0,0);
    add(0,1,0,0, 2, 6, L_RR, 0,0);
    add(0,1,0,0, 2, 7, L_RR, 1,0);
    add(0,1,0,1, 1, 7, L_RR, 1,1);
    add(0,1,0,0, 3, 7, L_RR, 1,0);
    add(0,1,0,0, 8, 1, L_GR, 0,0);
    add(0,1,0,0, 3, 2, L_YR, 0,0);
    add(0,1,0,0, 2, 3, L_RR, 0,0);
    add(0,1,0,0, 8, 4, L_RG, 0,0);
    add(0,1,0,0, 3, 5, L_RY, 0,0);
    add(0,1,0,0, 2, 6, L_RR, 0,0);
    add(0,1,0,0, 6, 7, L_RR, 1,0);
    add(0,1,0,0,12, 1, L_GR, 0,0);
    // Pending request discarded by reset mid-EW_YELLOW
    add(0,1,0,1, 1, 1, L_GR, 0,1);
    add(0,1,0,0, 3, 2, L_YR, 0,0);
    add(0,1,0,0, 2, 3, L_RR, 0,0);
    add(0,1,0,0, 8, 4, L_RG, 0,0);
    add(0,1,0,0, 1, 5, L_RY, 0,0);
    add(1,1,0,0, 1, 0, L_RR, 0,0);
    add(0,1,0,0, 1, 0, L_RR, 0,0);
    add(0,1,0,0, 1, 1, L_GR, 0,0);
    add(0,1,0,0,20, 1, L_GR, 0,0);
`endif

    rst = 1'b1; tick_en = 1'b1; ew_car = 1'b0; ns_car = 1'b0;
`ifdef PED_REQ_EN
    ped_req = 1'b0;
`endif
    foreach (vecs[k]) begin
      for (int j = 0; j < int'(vecs[k].cnt); j++) begin
        rst     = vecs[k].rst;
        tick_en = vecs[k].tick;
        ew_car  = vecs[k].ew;
        ns_car  = ~vecs[k].ew;
`ifdef PED_REQ_EN
        ped_req = vecs[k].ped;
`endif
        step();
        check($sformatf("vec%0d.%0d", k, j), vecs[k].ph, vecs[k].lamps, vecs[k].walk, vecs[k].ack);
      end
    end

    // Strobe every 4th cycle: each phase lasts 4x its tick count
    do_reset();
    base = '{0, 8, 3, 2, 8, 3, 2};
    foreach (len[p]) len[p] = 0;
    prev = phase; run = 0; started = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick_en = (cyc % 4 == 0);
      ew_car  = 1'b1;
      step();
      cur = phase;
      if (cur != prev) begin
        if (started != 0 && len[prev] == 0) len[prev] = run;
        started = 1;
        run = 1;
      end else begin
        run++;
      end
      prev = cur;
    end
    for (int p = 1; p <= 6; p++) begin
      n_checks++;
      if (len[p] != 4 * base[p]) begin
        n_fail++;
        $display("FAIL tick4_len_phase%0d: got %0d cycles, want %0d", p, len[p], 4 * base[p]);
      end
    end

    // tick_en low mid-yellow freezes the phase
    do_reset();
    ew_car = 1'b1; tick_en = 1'b1;
    for (int i = 0; i < 30 && phase !== 3'd2; i++) step();
    check("freeze_reach_yellow", 3'd2, L_YR, 1'b0, 1'b0);
    step();
    check("freeze_pre", 3'd2, L_YR, 1'b0, 1'b0);
    tick_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("freeze_hold%0d", i), 3'd2, L_YR, 1'b0, 1'b0);
    end
    tick_en = 1'b1;
    step();
    check("freeze_last_yellow", 3'd2, L_YR, 1'b0, 1'b0);
    step();
    check("freeze_to_allred", 3'd3, L_RR, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Sequencer for a two-way intersection built around the existing three-lamp traffic-light behaviour. It drives two red/yellow/green lamp sets (north-south main road, east-west side road) from a single phase state machine. Phase durations are counted on a timebase strobe, and all lamp changes are interlocked through all-red clearance phases. The block sits between the vehicle/pedestrian detectors and the lamp drivers.

## Interface
- GREEN_TICKS, 8: minimum green duration in ticks, both directions
- YELLOW_TICKS, 3: yellow duration in ticks
- ALLRED_TICKS, 2: all-red clearance duration in ticks
- WALK_TICKS, 6: pedestrian walk duration in ticks
- TW, 8: phase timer width; every *_TICKS value is between 1 and 2^TW-1
- clk  input  1  single clock
- reset  input  1  synchronous, active-high
- tick_en  input  1  timebase strobe; phase timer advances only on cycles where this is high
- ns_car  input  1  north-south vehicle detector (level)
- ew_car  input  1  east-west vehicle detector (level)
- ped_req  input  1  pedestrian request (present only with PED_REQ_EN)
- ped_ack  output  1  one-cycle pulse when a request is latched (present only with PED_REQ_EN)
- walk  output  1  walk lamp (present only with PED_REQ_EN)
- ns_red, ns_yellow, ns_green  output  1 each  NS lamps
- ew_red, ew_yellow, ew_green  output  1 each  EW lamps
- phase  output  3  current state encoding, for debug

## Operation
- Phase encodings:
  - 0 RST_RED
  - 1 NS_GREEN
  - 2 NS_YELLOW
  - 3 RED_NS2EW
  - 4 EW_GREEN
  - 5 EW_YELLOW
  - 6 RED_EW2NS
  - 7 PED_WALK
- Timer behaviour:
  - On entry to a phase, the timer loads that phase's *_TICKS-1.
  - The timer decrements on tick_en.
  - A phase expires on a cycle where timer==0 and tick_en==1.
- Phase transitions, taken on expiry:
  - RST_RED→NS_GREEN.
  - NS_GREEN→NS_YELLOW, only if ew_car or ped_pending is high at expiry. Otherwise NS green rests: the timer holds at 0 and the check repeats on every tick_en.
  - NS_YELLOW→RED_NS2EW.
  - RED_NS2EW→EW_GREEN.
  - EW_GREEN→EW_YELLOW, unconditionally. ns_car is informational only and feeds no decision.
  - EW_YELLOW→RED_EW2NS.
  - RED_EW2NS→PED_WALK if ped_pending, else NS_GREEN.
  - PED_WALK→NS_GREEN.
- Pedestrian-only demand still passes through a full EW green phase before the walk phase.
- ped_pending register:
  - Set on any cycle where ped_req==1.
  - Cleared on entry to PED_WALK.
  - When set and clear coincide, set wins; that request is served on the next round.
- ped_ack pulses on the cycle ped_pending goes 0→1. Requests while already pending produce no ack.
- Lamp decoding (Moore, decoded from the registered state; exactly one lamp per direction is lit):
  - NS green in NS_GREEN, NS yellow in NS_YELLOW, NS red in every other phase.
  - EW decoding mirrors NS.
  - walk=1 only in PED_WALK.
- Reset values:
  - phase = RST_RED, with its timer loaded with ALLRED_TICKS-1.
  - ns_red = ew_red = 1; all other lamps 0; walk = 0; ped_ack = 0; ped_pending = 0.

## Timing
- Lamp outputs change on the clock edge that registers the new phase, i.e. one cycle after the expiry condition is sampled.
- With tick_en held at 1, a phase of N ticks lasts exactly N cycles.
- With tick_en at 1 every k-th cycle, a phase lasts N strobes.
- tick_en low freezes the timer and the phase. Detector and ped_req inputs are still sampled every cycle.
- Reset asserted mid-phase returns to the reset state on the next edge, whatever the phase or timer value. This includes mid-yellow and mid-walk, and it discards ped_pending.
- Green is never adjacent to green: every direction change traverses yellow and then all-red.

## Configuration
- PED_REQ_EN defined:
  - ped_req, ped_ack and walk ports exist.
  - ped_pending is implemented.
  - PED_WALK is reachable.
- PED_REQ_EN undefined:
  - Those ports and the ped_pending register are removed.
  - NS_GREEN leaves on ew_car only.
  - RED_EW2NS always goes to NS_GREEN.
  - Encoding 7 is unreachable; if it is ever entered, the next edge forces RST_RED.

## Structure
- Package intersection_pkg holds:
  - the 3-bit phase enum with the encodings above;
  - default tick constants;
  - the lamp-vector helper type.
- Sub-module phase_timer: TW-bit loadable down-counter.
  - Inputs: load, load_val, tick_en.
  - Output: expire, equal to count==0 && tick_en.
  - Instantiated once by the controller.

## Test plan
- Reset held 3 cycles, defaults, tick_en=1 → ns_red=ew_red=1 and phase=0 during reset. NS green appears 2 cycles after release.
- No demand, run 50 cycles → phase stays 1 and NS green stays lit after the 8-cycle minimum.
- ew_car=1 from cycle 20, tick_en=1 → NS green holds ≥8 cycles, then yellow 3, all-red 2, EW green 8, yellow 3, all-red 2, back to NS green.
- tick_en pulsed every 4th cycle → each phase length ×4. Toggling tick_en low mid-yellow freezes yellow.
- ped_req one-cycle pulse during NS green → ped_ack the next cycle, then a full cycle with walk=1 for 6 cycles in phase 7 and both directions red, then NS green. A second ped_req inside the walk is served on the following round.
- reset asserted mid-EW_YELLOW with ped_pending=1 → next edge gives phase 0, both directions red, walk=0, and the pending request is lost.
